// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_queue
//  Description : DEPTH-entry show-ahead instruction queue between IF and ID.
//                Decouples fetch from decode with a valid/ready handshake.
//                An EX redirect (jump_i) drops every queued entry in one
//                cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
  parameter int ADDR_W    = 32,
  parameter int INST_W    = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  // fetch side
  input  logic                     if_valid_i,
  input  logic [ADDR_W-1:0]        if_pc_i,
  input  logic [INST_W-1:0]        if_inst_i,
  output logic                     full_o,
  output logic                     afull_o,
  // decode side
  input  logic                     id_ready_i,
  output logic                     id_valid_o,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [INST_W-1:0]        id_inst_o,
  // redirect
  input  logic                     jump_i,
  // status
  output logic [$clog2(DEPTH):0]   count_o
);

  // Pointer and occupancy widths. The count needs one extra bit so that a
  // completely full queue (count == DEPTH) is representable.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_AFULL_CNT = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] c_CNT_ZERO  = '0;

  // Storage; contents are never reset, only the pointers and count.
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic [INST_W-1:0] r_mem_inst [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_next;

  // Status flags decoded from registered count only, so neither full_o nor
  // id_valid_o depends combinationally on id_ready_i or if_valid_i.
  always_comb begin
    w_full  = (r_count == c_DEPTH_CNT);
    w_valid = (r_count != c_CNT_ZERO);
  end

  // Handshake qualification. A push while full is dropped outright: there is
  // no same-cycle credit for a concurrent pop.
  always_comb begin
    w_push       = if_valid_i & ~w_full;
    w_pop        = id_ready_i & w_valid;
    w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Pointer and occupancy update: reset beats jump, jump beats push/pop.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (jump_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Entry write; the wrong-path instruction presented during a jump (or any
  // reset cycle) is never stored.
  always_ff @(posedge clk) begin
    if (w_push && !jump_i && !rst) begin
      r_mem_pc[r_wr_ptr]   <= if_pc_i;
      r_mem_inst[r_wr_ptr] <= if_inst_i;
    end
  end

  // Show-ahead head presentation, gated to the all-zero bubble when empty so
  // ID sees the same NOP encoding it always has.
  always_comb begin
    id_valid_o = w_valid;
    id_pc_o    = w_valid ? r_mem_pc[r_rd_ptr]   : '0;
    id_inst_o  = w_valid ? r_mem_inst[r_rd_ptr] : '0;
  end

  // Remaining status outputs.
  always_comb begin
    full_o  = w_full;
    afull_o = (r_count >= c_AFULL_CNT);
    count_o = r_count;
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_queue
//  Description : Self-checking bench for if_id_queue. Directed scenarios are
//                followed by a randomized run; every cycle the DUT outputs
//                are compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

  localparam int ADDR_W    = 32;
  localparam int INST_W    = 32;
  localparam int DEPTH     = 4;
  localparam int AFULL_LVL = DEPTH - 1;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              if_valid_i;
  logic [ADDR_W-1:0] if_pc_i;
  logic [INST_W-1:0] if_inst_i;
  logic              full_o;
  logic              afull_o;
  logic              id_ready_i;
  logic              id_valid_o;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              jump_i;
  logic [CNT_W-1:0]  count_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of {pc, inst} entries.
  logic [ADDR_W+INST_W-1:0] model_q [$];

  if_id_queue #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .AFULL_LVL(AFULL_LVL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid_i(if_valid_i),
    .if_pc_i   (if_pc_i),
    .if_inst_i (if_inst_i),
    .full_o    (full_o),
    .afull_o   (afull_o),
    .id_ready_i(id_ready_i),
    .id_valid_o(id_valid_o),
    .id_pc_o   (id_pc_o),
    .id_inst_o (id_inst_o),
    .jump_i    (jump_i),
    .count_o   (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's current contents.
  task automatic check_outputs();
    int                sz;
    logic [ADDR_W-1:0] exp_pc;
    logic [INST_W-1:0] exp_inst;
    sz = model_q.size();
    exp_pc   = '0;
    exp_inst = '0;
    if (sz > 0) begin
      exp_pc   = model_q[0][ADDR_W+INST_W-1:INST_W];
      exp_inst = model_q[0][INST_W-1:0];
    end
    chk("count",    64'(count_o),    64'(sz));
    chk("id_valid", 64'(id_valid_o), 64'(sz != 0));
    chk("full",     64'(full_o),     64'(sz == DEPTH));
    chk("afull",    64'(afull_o),    64'(sz >= AFULL_LVL));
    chk("id_pc",    64'(id_pc_o),    64'(exp_pc));
    chk("id_inst",  64'(id_inst_o),  64'(exp_inst));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check after.
  task automatic step(input logic v, input logic [ADDR_W-1:0] pc,
                      input logic [INST_W-1:0] inst, input logic rdy,
                      input logic jmp, input logic rs);
    bit do_push;
    bit do_pop;
    if_valid_i = v;
    if_pc_i    = pc;
    if_inst_i  = inst;
    id_ready_i = rdy;
    jump_i     = jmp;
    rst        = rs;
    @(posedge clk);
    if (rs || jmp) begin
      model_q.delete();
    end else begin
      do_push = v && (model_q.size() < DEPTH);
      do_pop  = rdy && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, inst});
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst        = 1'b1;
    if_valid_i = 1'b0;
    if_pc_i    = '0;
    if_inst_i  = '0;
    id_ready_i = 1'b0;
    jump_i     = 1'b0;

    // Reset for two cycles with IF presenting an instruction: nothing stored.
    step(1'b1, 32'h100, 32'hDEAD, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h104, 32'hBEEF, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Fill with ID stalled, then a dropped fifth push, then drain.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(i * 4), 32'((i + 1) * 32'h11), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h10, 32'h55, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Streaming with pointer wrap: count holds at 1.
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush mid-stream with push and pop requested in the jump cycle.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h20 + 32'(i * 4), 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h40, 32'h400, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h80, 32'h800, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Full plus simultaneous pop: push dropped, then accepted next cycle.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h60 + 32'(i * 4), 32'h600 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h50, 32'h500, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h50, 32'h500, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Reset and jump together on a half-full queue, then resume.
    step(1'b1, 32'hA0, 32'hA00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA4, 32'hA04, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA8, 32'hA08, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'hB0, 32'hB00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB4, 32'hB04, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with varying push/pop pressure.
    for (int i = 0; i < 3000; i++) begin
      int          push_pct;
      int          pop_pct;
      logic        v;
      logic        rdy;
      logic        jmp;
      logic        rs;
      push_pct = ((i / 300) % 2 == 0) ? 80 : 30;
      pop_pct  = ((i / 450) % 2 == 0) ? 30 : 80;
      v   = ($urandom_range(99) < push_pct);
      rdy = ($urandom_range(99) < pop_pct);
      jmp = ($urandom_range(99) < 3);
      rs  = ($urandom_range(999) < 5);
      step(v, $urandom(), $urandom(), rdy, jmp, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry show-ahead instruction queue between IF and ID.
- Decouples fetch from decode, so IF keeps fetching while ID stalls.
- Explicit valid handshake replaces the zero-word bubble encoding.
- A jump (branch-redirect) flush from EX drops all queued instructions in one cycle.

Parameters:
- ADDR_W, 32, width of the PC field.
- INST_W, 32, width of the instruction field.
- DEPTH, 4, number of queue entries; power of two, at least 2.
- AFULL_LVL, DEPTH-1, occupancy at or above which afull_o asserts; range 1..DEPTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- if_valid_i  in  1  IF presents a fetched instruction this cycle.
- if_pc_i  in  ADDR_W  PC of the fetched instruction.
- if_inst_i  in  INST_W  fetched instruction word.
- full_o  out  1  queue holds DEPTH entries; IF must not count on the push being accepted.
- afull_o  out  1  count_o >= AFULL_LVL; early back-pressure so IF can stop issuing memory requests.
- id_ready_i  in  1  ID consumes the head entry this cycle; low means ID is stalled.
- id_valid_o  out  1  head entry is valid.
- id_pc_o  out  ADDR_W  head PC; zero when empty.
- id_inst_o  out  INST_W  head instruction; zero when empty.
- jump_i  in  1  EX redirect; flushes the queue.
- count_o  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rd_ptr, wr_ptr and count are cleared to 0.
  - id_valid_o, full_o and afull_o are 0; id_pc_o and id_inst_o are 0.
  - Storage contents need not be cleared.
  - Reset takes priority over all other inputs, including mid-stream.
- Definitions:
  - push = if_valid_i & ~full_o.
  - pop = id_ready_i & id_valid_o.
  - full_o = (count == DEPTH).
  - id_valid_o = (count != 0).
  - Both full_o and id_valid_o are decoded from registered count, so neither depends combinationally on id_ready_i.
- Push:
  - Writes {if_pc_i, if_inst_i} at wr_ptr.
  - wr_ptr increments modulo DEPTH; natural wrap is required since DEPTH is a power of two.
  - If if_valid_i is high while full_o is high, the instruction is dropped. IF must hold or refetch it. No same-cycle pop credit is given.
- Pop:
  - rd_ptr increments modulo DEPTH.
  - The next entry, if any, appears on the id_* outputs in the following cycle.
- Show-ahead outputs:
  - id_pc_o and id_inst_o are driven from the entry at rd_ptr, gated to zero when count == 0.
  - An empty queue therefore presents the same all-zero bubble that ID already treats as a NOP.
- Latency: an instruction pushed at edge N is visible on the id_* outputs after edge N when the queue was empty. There is no combinational IF-to-ID bypass.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal at any occupancy from 1 to DEPTH-1.
- Pop when empty: cannot occur, because pop requires id_valid_o. id_ready_i is ignored while empty.
- Flush (jump_i=1 at a clock edge, rst=0):
  - rd_ptr, wr_ptr and count are set to 0.
  - Any push or pop in that same cycle is discarded.
  - The instruction on if_* during the jump cycle belongs to the wrong path and is never stored.
  - After the flush edge, id_valid_o is 0 and the id_* outputs are 0.
- Priority: rst > jump_i > push/pop.
- Count arithmetic:
  - count_next = count + push - pop, computed at width clog2(DEPTH)+1.
  - count never exceeds DEPTH and never underflows.
- afull_o is registered-equivalent: it is decoded from the registered count only.

Test Plan:
- Reset then idle: assert rst for 2 cycles with if_valid_i=1 -> count_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, no entry stored.
- Fill and drain, DEPTH=4, id_ready_i=0:
  - Push PCs 0x00, 0x04, 0x08, 0x0C with instructions 0x11..0x44 -> after the 4th edge full_o=1, afull_o=1 (after the 3rd edge as well), count_o=4.
  - A 5th push of PC 0x10 is dropped.
  - Raise id_ready_i -> outputs PCs 0x00, 0x04, 0x08, 0x0C in order on consecutive cycles, then id_valid_o=0.
- Streaming with wrap: if_valid_i=1 and id_ready_i=1 continuously for 10 cycles, PCs 0x00..0x24 -> count_o holds at 1 after the first edge, each PC appears exactly once in order, and pointers wrap past index 3 without loss.
- Flush mid-stream: queue holds 3 entries; assert jump_i with if_valid_i=1 (PC 0x40) and id_ready_i=1 -> next cycle count_o=0, id_valid_o=0, id_inst_o=0. A subsequent push of PC 0x80 appears as the head one cycle later.
- Full plus simultaneous pop: queue full, if_valid_i=1 (PC 0x50), id_ready_i=1 -> head pops, PC 0x50 is dropped, count_o=3, full_o=0. The next cycle's push of 0x50 is accepted.
- Reset versus jump: assert rst and jump_i together on a half-full queue -> reset state results (count_o=0, all outputs 0). Deasserting both and pushing resumes normally from pointer 0.
